lmi_region_decode: RTL and testbench
====================================

LMI_REGION_DECODE -- requirements
Module: lmi_region_decode

Interface
REQ-001 Parameter NUM_REGIONS, default 4, SHALL set the number of programmable regions (1..16).
REQ-002 Parameter TOP_LO, default 4, SHALL set the compare granularity; address bits below TOP_LO are ignored.
REQ-003 Parameter IDX_W, default 2, SHALL set the region index width (>= clog2(NUM_REGIONS), minimum 1).
REQ-004 Clocking SHALL be one clock, CLK; RESET SHALL be asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- CLK, in, 1: clock.
- RESET, in, 1: asynchronous active-high reset.
- REQ_VALID, in, 1: lookup request.
- REQ_ADDR, in, 32: lookup address.
- REQ_READY, out, 1: request accepted when both VALID and READY are high.
- RSP_VALID, out, 1: response available.
- RSP_READY, in, 1: response consumed.
- RSP_HIT, out, 1: address fell in an enabled region.
- RSP_REGION, out, IDX_W: index of the winning region.
- CFG_WE, in, 1: configuration write strobe.
- CFG_IDX, in, IDX_W: region selected for the write.
- CFG_SEL, in, 1: 0 = base register, 1 = top register.
- CFG_WDATA, in, 32: write data; bits [31:TOP_LO] are the bound; bit 0 of a base write is the region enable.
- ERR_VALID, out, 1: sticky miss flag.
- ERR_ADDR, out, 32: first missing address.
- ERR_CLR, in, 1: clears ERR_VALID.

Function
REQ-006 Region i SHALL hit when all of the following hold:
- the region is enabled;
- REQ_ADDR[31:TOP_LO] >= BASE_i[31:TOP_LO];
- REQ_ADDR[31:TOP_LO] <= TOP_i[31:TOP_LO].
All compares SHALL be unsigned.
REQ-007 When several regions hit, the lowest index SHALL win; on a miss, RSP_REGION SHALL be 0 and RSP_HIT SHALL be 0.
REQ-008 A region with BASE greater than TOP SHALL never hit.
REQ-009 Latency SHALL be exactly one cycle: a request accepted at edge N presents its response from edge N.
REQ-010 REQ_READY SHALL equal (!RSP_VALID | RSP_READY), giving full throughput with back-pressure.
REQ-011 RSP_VALID, RSP_HIT and RSP_REGION SHALL hold stable while RSP_VALID=1 and RSP_READY=0.
REQ-012 A configuration write and a lookup in the same cycle: the lookup SHALL use the pre-write register values.
REQ-013 CFG_WE with CFG_IDX >= NUM_REGIONS SHALL be ignored.
REQ-014 Error capture on a miss:
- the first accepted miss with ERR_VALID=0 SHALL set ERR_VALID and load ERR_ADDR;
- later misses SHALL NOT overwrite ERR_ADDR.
REQ-015 ERR_CLR SHALL clear ERR_VALID on the next edge; if ERR_CLR and an accepted miss occur in the same cycle, the new miss SHALL be captured.

Reset
REQ-016 On RESET the following SHALL be 0:
- RSP_VALID, RSP_HIT, RSP_REGION;
- ERR_VALID, ERR_ADDR;
- all BASE, TOP and enable registers, so every region is disabled.
REQ-017 RESET asserted mid-transaction SHALL discard any pending response with no residual output.
REQ-018 REQ_READY SHALL be 1 from the first edge after RESET deasserts.

Configuration
REQ-019 With macro LMI_REGION_LOCK_EN defined, input port CFG_LOCK (1 bit) SHALL exist:
- a cycle with CFG_LOCK=1 SHALL set an internal lock bit;
- while the lock bit is set, all CFG_WE writes SHALL be ignored;
- only RESET SHALL clear the lock bit.
REQ-020 Without LMI_REGION_LOCK_EN, CFG_LOCK SHALL be absent and all in-range writes SHALL be accepted.

Structure
REQ-021 Package lmi_region_pkg SHALL hold:
- the CFG_SEL encodings (SEL_BASE, SEL_TOP);
- the enable bit position;
- the reset constants.
REQ-022 Sub-module lmi_region_cmp SHALL compute the single-region hit (enable and base/top compare) and be instantiated NUM_REGIONS times.
REQ-023 All state SHALL live in the top level.

Verification
REQ-024 Configure region 1 with base 0x1000_0000 (enabled) and top 0x1000_0FF0, then request 0x1000_0FF8 -> RSP_HIT=1, RSP_REGION=1, one cycle later.
REQ-025 Configure overlapping regions 0 and 2, then request an address inside both -> RSP_REGION=0.
REQ-026 Hold RSP_READY=0 for 3 cycles with REQ_VALID=1 -> REQ_READY=0 and the response is stable; release -> back-to-back responses, one per cycle.
REQ-027 Send miss addresses 0x2000_0000 then 0x3000_0000 -> ERR_ADDR=0x2000_0000; then apply ERR_CLR together with a miss at 0x4000_0000 -> ERR_VALID=1, ERR_ADDR=0x4000_0000.
REQ-028 With LMI_REGION_LOCK_EN defined: pulse CFG_LOCK, then write region 0 top -> value unchanged; after RESET, the write succeeds.
REQ-029 Assert RESET while RSP_VALID=1 -> all outputs 0 and all regions disabled; a following request -> RSP_HIT=0 and ERR_VALID=1.

Source files
------------

// File: rtl/lmi_region_pkg.sv
// Shared definitions for the LMI region decoder: configuration select
// encodings, the enable bit position inside a base write, and reset values.
package lmi_region_pkg;

  typedef enum logic {
    SEL_BASE = 1'b0,
    SEL_TOP  = 1'b1
  } cfg_sel_e;

  localparam int EN_BIT = 0;

  localparam logic [31:0] RST_ADDR  = 32'h0000_0000;
  localparam logic        RST_EN    = 1'b0;
  localparam logic        RST_VALID = 1'b0;
  localparam logic        RST_HIT   = 1'b0;

endpackage

// File: rtl/lmi_region_cmp.sv
// Single-region hit detector: an enabled region hits when the truncated
// address lies within [base, top]. All compares are unsigned, so a region
// whose base exceeds its top can never hit.
module lmi_region_cmp #(
  parameter int BW = 28
) (
  input  logic          en_i,
  input  logic [BW-1:0] addr_i,
  input  logic [BW-1:0] base_i,
  input  logic [BW-1:0] top_i,
  output logic          hit_o
);

  assign hit_o = en_i && (addr_i >= base_i) && (addr_i <= top_i);

endmodule

// File: rtl/lmi_region_decode.sv
// LMI region decoder: programmable base/top regions, one-cycle registered
// lookup with valid/ready handshake on both sides, and sticky miss capture.
// Optional feature: define LMI_REGION_LOCK_EN to add the CFG_LOCK input,
// which freezes the configuration registers until the next reset.
module lmi_region_decode
  import lmi_region_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int TOP_LO      = 4,
  parameter int IDX_W       = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  input  logic [31:0]      REQ_ADDR,
  output logic             REQ_READY,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_HIT,
  output logic [IDX_W-1:0] RSP_REGION,
  input  logic             CFG_WE,
  input  logic [IDX_W-1:0] CFG_IDX,
  input  logic             CFG_SEL,
  input  logic [31:0]      CFG_WDATA,
  input  logic             ERR_CLR,
`ifdef LMI_REGION_LOCK_EN
  input  logic             CFG_LOCK,
`endif
  output logic             ERR_VALID,
  output logic [31:0]      ERR_ADDR
);

  localparam int BW = 32 - TOP_LO;
  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_REGIONS);

  logic [BW-1:0]          base_q [NUM_REGIONS];
  logic [BW-1:0]          base_d [NUM_REGIONS];
  logic [BW-1:0]          top_q  [NUM_REGIONS];
  logic [BW-1:0]          top_d  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_q;
  logic [NUM_REGIONS-1:0] en_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q,   rsp_hit_d;
  logic [IDX_W-1:0] rsp_region_q, rsp_region_d;
  logic             err_valid_q, err_valid_d;
  logic [31:0]      err_addr_q,  err_addr_d;

  logic [NUM_REGIONS-1:0] hit_vec;
  logic                   lk_hit;
  logic [IDX_W-1:0]       lk_region;
  logic                   req_accept;
  logic                   cfg_locked;
  logic                   cfg_write;
  logic                   unused_wdata;

  // Only the bound bits and the enable bit of the write data are stored.
  assign unused_wdata = ^CFG_WDATA;

  assign REQ_READY  = !rsp_valid_q || RSP_READY;
  assign req_accept = REQ_VALID && REQ_READY;
  assign cfg_write  = CFG_WE && !cfg_locked && ({1'b0, CFG_IDX} < NUM_W);

  assign RSP_VALID  = rsp_valid_q;
  assign RSP_HIT    = rsp_hit_q;
  assign RSP_REGION = rsp_region_q;
  assign ERR_VALID  = err_valid_q;
  assign ERR_ADDR   = err_addr_q;

`ifdef LMI_REGION_LOCK_EN
  logic lock_q, lock_d;

  assign lock_d     = lock_q || CFG_LOCK;
  assign cfg_locked = lock_q;

  // Lock bit is sticky; only reset releases it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end
`else
  assign cfg_locked = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cmp
    lmi_region_cmp #(.BW(BW)) u_cmp (
      .en_i   (en_q[g]),
      .addr_i (REQ_ADDR[31:TOP_LO]),
      .base_i (base_q[g]),
      .top_i  (top_q[g]),
      .hit_o  (hit_vec[g])
    );
  end

  // Priority select: scanning downward lets the lowest hitting index win.
  always_comb begin
    lk_hit    = 1'b0;
    lk_region = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        lk_hit    = 1'b1;
        lk_region = IDX_W'(i);
      end
    end
  end

  // Configuration register updates; lookups in the same cycle see old values.
  always_comb begin
    base_d = base_q;
    top_d  = top_q;
    en_d   = en_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cfg_write && (CFG_IDX == IDX_W'(i))) begin
        if (cfg_sel_e'(CFG_SEL) == SEL_BASE) begin
          base_d[i] = CFG_WDATA[31:TOP_LO];
          en_d[i]   = CFG_WDATA[EN_BIT];
        end else begin
          top_d[i]  = CFG_WDATA[31:TOP_LO];
        end
      end
    end
  end

  // Response holding register and sticky first-miss capture.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_region_d = rsp_region_q;
    err_valid_d  = err_valid_q;
    err_addr_d   = err_addr_q;
    if (req_accept) begin
      rsp_valid_d  = 1'b1;
      rsp_hit_d    = lk_hit;
      rsp_region_d = lk_region;
    end else if (RSP_READY) begin
      rsp_valid_d  = 1'b0;
    end
    if (req_accept && !lk_hit && (!err_valid_q || ERR_CLR)) begin
      err_valid_d = 1'b1;
      err_addr_d  = REQ_ADDR;
    end else if (ERR_CLR) begin
      err_valid_d = 1'b0;
    end
  end

  // State registers; reset disables every region and drops any response.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i] <= RST_ADDR[31:TOP_LO];
        top_q[i]  <= RST_ADDR[31:TOP_LO];
      end
      en_q         <= {NUM_REGIONS{RST_EN}};
      rsp_valid_q  <= RST_VALID;
      rsp_hit_q    <= RST_HIT;
      rsp_region_q <= '0;
      err_valid_q  <= RST_VALID;
      err_addr_q   <= RST_ADDR;
    end else begin
      base_q       <= base_d;
      top_q        <= top_d;
      en_q         <= en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_region_q <= rsp_region_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_lmi_region_decode.sv
// Self-checking bench for lmi_region_decode: directed scenarios followed by
// randomized traffic, all compared against a behavioural region model.
// Covers the optional LMI_REGION_LOCK_EN feature when that macro is defined.
module tb_lmi_region_decode;

  localparam int NUM = 4;
  localparam int TLO = 4;
  localparam int IW  = 2;

  logic          CLK;
  logic          RESET;
  logic          REQ_VALID;
  logic [31:0]   REQ_ADDR;
  logic          REQ_READY;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic          RSP_HIT;
  logic [IW-1:0] RSP_REGION;
  logic          CFG_WE;
  logic [IW-1:0] CFG_IDX;
  logic          CFG_SEL;
  logic [31:0]   CFG_WDATA;
  logic          ERR_CLR;
  logic          ERR_VALID;
  logic [31:0]   ERR_ADDR;
`ifdef LMI_REGION_LOCK_EN
  logic          CFG_LOCK;
`endif

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] mBase [NUM];
  logic [31:0] mTop  [NUM];
  bit          mEn   [NUM];
  bit          mLock;
  bit          expValid;
  bit          expHit;
  int          expRegion;
  bit          mErrValid;
  logic [31:0] mErrAddr;

  lmi_region_decode #(.NUM_REGIONS(NUM), .TOP_LO(TLO), .IDX_W(IW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ_VALID  (REQ_VALID),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_READY  (REQ_READY),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_HIT    (RSP_HIT),
    .RSP_REGION (RSP_REGION),
    .CFG_WE     (CFG_WE),
    .CFG_IDX    (CFG_IDX),
    .CFG_SEL    (CFG_SEL),
    .CFG_WDATA  (CFG_WDATA),
    .ERR_CLR    (ERR_CLR),
`ifdef LMI_REGION_LOCK_EN
    .CFG_LOCK   (CFG_LOCK),
`endif
    .ERR_VALID  (ERR_VALID),
    .ERR_ADDR   (ERR_ADDR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference lookup: first enabled region whose granule range holds addr.
  function automatic int modelLookup(input logic [31:0] addr);
    for (int i = 0; i < NUM; i++) begin
      if (mEn[i] && ((addr >> TLO) >= (mBase[i] >> TLO)) && ((addr >> TLO) <= (mTop[i] >> TLO)))
        return i;
    end
    return -1;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NUM; i++) begin
      mBase[i] = 32'h0;
      mTop[i]  = 32'h0;
      mEn[i]   = 1'b0;
    end
    mLock     = 1'b0;
    expValid  = 1'b0;
    expHit    = 1'b0;
    expRegion = 0;
    mErrValid = 1'b0;
    mErrAddr  = 32'h0;
  endtask

  // Drive one cycle of inputs, step the model across the edge, check outputs.
  task automatic applyStimulus(input bit reqValid, input logic [31:0] addr, input bit rspReady,
                               input bit cfgWe, input int cfgIdx, input bit cfgSel,
                               input logic [31:0] wdata, input bit errClr, input bit lock);
    bit accept;
    int r;
    REQ_VALID = reqValid;
    REQ_ADDR  = addr;
    RSP_READY = rspReady;
    CFG_WE    = cfgWe;
    CFG_IDX   = IW'(cfgIdx);
    CFG_SEL   = cfgSel;
    CFG_WDATA = wdata;
    ERR_CLR   = errClr;
`ifdef LMI_REGION_LOCK_EN
    CFG_LOCK  = lock;
`endif
    #1;
    checkOutput("req_ready", 32'(REQ_READY), 32'(!expValid || rspReady));
    accept = reqValid && (!expValid || rspReady);
    r = modelLookup(addr);
    @(posedge CLK);
    #1;
    if (accept && (r < 0) && (!mErrValid || errClr)) begin
      mErrValid = 1'b1;
      mErrAddr  = addr;
    end else if (errClr) begin
      mErrValid = 1'b0;
    end
    if (accept) begin
      expValid  = 1'b1;
      expHit    = (r >= 0);
      expRegion = (r >= 0) ? r : 0;
    end else if (rspReady) begin
      expValid  = 1'b0;
    end
    if (cfgWe && (cfgIdx < NUM) && !mLock) begin
      if (cfgSel == 1'b0) begin
        mBase[cfgIdx] = wdata;
        mEn[cfgIdx]   = wdata[0];
      end else begin
        mTop[cfgIdx]  = wdata;
      end
    end
`ifdef LMI_REGION_LOCK_EN
    if (lock) mLock = 1'b1;
`else
    if (lock) mLock = 1'b0;
`endif
    checkOutput("rsp_valid", 32'(RSP_VALID), 32'(expValid));
    if (expValid) begin
      checkOutput("rsp_hit", 32'(RSP_HIT), 32'(expHit));
      checkOutput("rsp_region", 32'(RSP_REGION), 32'(expRegion));
    end
    checkOutput("err_valid", 32'(ERR_VALID), 32'(mErrValid));
    checkOutput("err_addr", ERR_ADDR, mErrAddr);
  endtask

  task automatic cfgWrite(input int idx, input bit sel, input logic [31:0] data);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, idx, sel, data, 1'b0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] addr);
    applyStimulus(1'b1, addr, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock.
  task automatic doReset();
    REQ_VALID = 1'b0;
    REQ_ADDR  = 32'h0;
    RSP_READY = 1'b0;
    CFG_WE    = 1'b0;
    CFG_IDX   = '0;
    CFG_SEL   = 1'b0;
    CFG_WDATA = 32'h0;
    ERR_CLR   = 1'b0;
`ifdef LMI_REGION_LOCK_EN
    CFG_LOCK  = 1'b0;
`endif
    RESET = 1'b1;
    #1;
    checkOutput("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    checkOutput("rst_rsp_hit", 32'(RSP_HIT), 32'h0);
    checkOutput("rst_rsp_region", 32'(RSP_REGION), 32'h0);
    checkOutput("rst_err_valid", 32'(ERR_VALID), 32'h0);
    checkOutput("rst_err_addr", ERR_ADDR, 32'h0);
    resetModel();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    checkOutput("rst_req_ready", 32'(REQ_READY), 32'h1);
  endtask

  initial begin
    RESET     = 1'b1;
    REQ_VALID = 1'b0;
    REQ_ADDR  = 32'h0;
    RSP_READY = 1'b0;
    CFG_WE    = 1'b0;
    CFG_IDX   = '0;
    CFG_SEL   = 1'b0;
    CFG_WDATA = 32'h0;
    ERR_CLR   = 1'b0;
`ifdef LMI_REGION_LOCK_EN
    CFG_LOCK  = 1'b0;
`endif
    resetModel();
    @(posedge CLK);
    #1;
    doReset();

    // Error capture: first miss sticks, clear plus new miss recaptures.
    lookup(32'h2000_0000);
    lookup(32'h3000_0000);
    checkOutput("err_first_addr", ERR_ADDR, 32'h2000_0000);
    applyStimulus(1'b1, 32'h4000_0000, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("err_clr_valid", 32'(ERR_VALID), 32'h1);
    checkOutput("err_clr_addr", ERR_ADDR, 32'h4000_0000);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("err_cleared", 32'(ERR_VALID), 32'h0);

    // Region 1 top-boundary hit with one-cycle latency.
    cfgWrite(1, 1'b0, 32'h1000_0001);
    cfgWrite(1, 1'b1, 32'h1000_0FF0);
    lookup(32'h1000_0FF8);
    checkOutput("top_edge_hit", 32'(RSP_HIT), 32'h1);
    checkOutput("top_edge_region", 32'(RSP_REGION), 32'h1);
    lookup(32'h1000_1000);
    checkOutput("past_top_miss", 32'(RSP_HIT), 32'h0);

    // Overlapping regions 0 and 2: the lower index wins.
    cfgWrite(0, 1'b0, 32'h5800_0001);
    cfgWrite(0, 1'b1, 32'h5800_FFF0);
    cfgWrite(2, 1'b0, 32'h5800_8001);
    cfgWrite(2, 1'b1, 32'h5801_0000);
    lookup(32'h5800_9000);
    checkOutput("overlap_region", 32'(RSP_REGION), 32'h0);
    lookup(32'h5801_0004);
    checkOutput("overlap_upper_region", 32'(RSP_REGION), 32'h2);

    // Back-pressure: response stays put, then drains one per cycle.
    lookup(32'h1000_0010);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h5800_9000, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bp_held_region", 32'(RSP_REGION), 32'h1);
    lookup(32'h5800_9000);
    lookup(32'h5801_0004);
    lookup(32'h1000_0020);

    // Write and lookup in the same cycle use the pre-write configuration.
    cfgWrite(3, 1'b1, 32'h5000_00F0);
    applyStimulus(1'b1, 32'h5000_0010, 1'b1, 1'b1, 3, 1'b0, 32'h5000_0001, 1'b0, 1'b0);
    checkOutput("pre_write_miss", 32'(RSP_HIT), 32'h0);
    lookup(32'h5000_0010);
    checkOutput("post_write_region", 32'(RSP_REGION), 32'h3);

    // A region with base above top never hits, even at its bounds.
    cfgWrite(2, 1'b0, 32'h6000_0101);
    cfgWrite(2, 1'b1, 32'h6000_0000);
    lookup(32'h6000_0100);
    checkOutput("inverted_miss", 32'(RSP_HIT), 32'h0);
    lookup(32'h6000_0000);

    // Disabling a region via bit 0 of the base write.
    cfgWrite(1, 1'b0, 32'h1000_0000);
    lookup(32'h1000_0FF8);
    checkOutput("disabled_miss", 32'(RSP_HIT), 32'h0);

`ifdef LMI_REGION_LOCK_EN
    // Lock freezes configuration until reset.
    cfgWrite(0, 1'b0, 32'h7000_0001);
    cfgWrite(0, 1'b1, 32'h7000_00F0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    cfgWrite(0, 1'b1, 32'h7000_FFF0);
    lookup(32'h7000_1000);
    checkOutput("locked_write_ignored", 32'(RSP_HIT), 32'h0);
    doReset();
    cfgWrite(0, 1'b0, 32'h7000_0001);
    cfgWrite(0, 1'b1, 32'h7000_FFF0);
    lookup(32'h7000_1000);
    checkOutput("unlocked_write_ok", 32'(RSP_HIT), 32'h1);
`endif

    // Randomized traffic over a compact address window so hits and misses mix.
    for (int n = 0; n < 400; n++) begin
      bit          rv;
      bit          rr;
      bit          we;
      bit          ec;
      logic [31:0] a;
      logic [31:0] d;
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 5) == 0);
      ec = ($urandom_range(0, 15) == 0);
      a  = ($urandom_range(0, 15) == 0) ? 32'h9000_0000 + $urandom_range(0, 255)
                                        : 32'h1000_0000 + $urandom_range(0, 4095);
      d  = 32'h1000_0000 + $urandom_range(0, 4095);
      applyStimulus(rv, a, rr, we, int'($urandom_range(0, NUM - 1)), 1'($urandom_range(0, 1)),
                    d, ec, 1'b0);
    end

    // Reset with a response pending wipes outputs and configuration.
    cfgWrite(1, 1'b0, 32'h1000_0001);
    cfgWrite(1, 1'b1, 32'h1000_0FF0);
    applyStimulus(1'b1, 32'h1000_0FF8, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_valid", 32'(RSP_VALID), 32'h1);
    doReset();
    lookup(32'h1000_0FF8);
    checkOutput("post_reset_hit", 32'(RSP_HIT), 32'h0);
    checkOutput("post_reset_err", 32'(ERR_VALID), 32'h1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
